// File: rtl/glitch_sweep.sv
// glitch_sweep: steps the glitch pulser through a delay x width grid with per-point repeats.
// Optional macro SWEEP_RESET_EN: request a target reset before every attempt instead of firing directly.
module glitch_sweep #(
   parameter int COOLDOWN_CYCLES = 1000,
   parameter int BUSY_WAIT_MAX   = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start_i,
   input  logic        abort_i,
   input  logic [15:0] delay_start_i,
   input  logic [15:0] delay_end_i,
   input  logic [15:0] delay_step_i,
   input  logic [7:0]  width_start_i,
   input  logic [7:0]  width_end_i,
   input  logic [7:0]  width_step_i,
   input  logic [7:0]  repeat_i,
   input  logic        pulser_busy_i,
   input  logic        reset_done_i,
   output logic [15:0] delay_o,
   output logic [7:0]  width_o,
   output logic        pulse_en_o,
   output logic        reset_en_o,
   output logic        busy_o,
   output logic        done_o
);

   typedef enum logic [3:0] {
      S_IDLE     = 4'd0,
      S_FIRE     = 4'd1,
      S_WAIT_HI  = 4'd2,
      S_WAIT_LO  = 4'd3,
      S_COOLDOWN = 4'd4,
      S_ADVANCE  = 4'd5,
      S_DONE     = 4'd6
`ifdef SWEEP_RESET_EN
      ,
      S_RST_REQ  = 4'd7,
      S_RST_WAIT = 4'd8
`endif
   } state_t;

`ifdef SWEEP_RESET_EN
   localparam state_t S_ATTEMPT = S_RST_REQ;
`else
   localparam state_t S_ATTEMPT = S_FIRE;
`endif

   localparam logic [15:0] BW_LAST = (BUSY_WAIT_MAX > 1) ? 16'(BUSY_WAIT_MAX - 1) : 16'd0;
   localparam logic [15:0] CD_LAST = (COOLDOWN_CYCLES > 1) ? 16'(COOLDOWN_CYCLES - 1) : 16'd0;
   localparam bit          CD_SKIP = (COOLDOWN_CYCLES == 0);

   state_t      r_state;
   state_t      w_next;
   logic [15:0] r_cnt;
   logic [15:0] r_delay;
   logic [7:0]  r_width;
   logic [7:0]  r_att;

   logic [15:0] r_dly_end;
   logic [15:0] r_dly_step;
   logic [7:0]  r_wid_start;
   logic [7:0]  r_wid_end;
   logic [7:0]  r_wid_step;
   logic [7:0]  r_rep;

   logic        w_accept;
   logic [8:0]  w_wid_sum;
   logic        w_wid_wrap;
   logic [16:0] w_dly_sum;
   logic        w_dly_wrap;
   logic        w_last_point;
   logic [8:0]  w_att_nxt;
   logic [7:0]  w_rep_eff;
   logic        w_rep_more;

   assign w_accept = (r_state == S_IDLE) && start_i && !abort_i;

   // Axis stepping: an axis wraps when its step is zero, the sum carries out, or it passes the end.
   assign w_wid_sum    = {1'b0, r_width} + {1'b0, r_wid_step};
   assign w_wid_wrap   = (r_wid_step == 8'd0) || w_wid_sum[8] || (w_wid_sum > {1'b0, r_wid_end});
   assign w_dly_sum    = {1'b0, r_delay} + {1'b0, r_dly_step};
   assign w_dly_wrap   = (r_dly_step == 16'd0) || w_dly_sum[16] || (w_dly_sum > {1'b0, r_dly_end});
   assign w_last_point = w_wid_wrap && w_dly_wrap;

   assign w_att_nxt  = {1'b0, r_att} + 9'd1;
   assign w_rep_eff  = (r_rep == 8'd0) ? 8'd1 : r_rep;
   assign w_rep_more = w_att_nxt < {1'b0, w_rep_eff};

`ifndef SWEEP_RESET_EN
   logic w_unused_reset_done;
   assign w_unused_reset_done = reset_done_i;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      if (abort_i) begin
         w_next = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE:     if (start_i) w_next = S_ATTEMPT;
            S_FIRE:     w_next = S_WAIT_HI;
`ifdef SWEEP_RESET_EN
            S_RST_REQ:  w_next = S_RST_WAIT;
            S_RST_WAIT: if (reset_done_i) w_next = S_WAIT_HI;
`endif
            S_WAIT_HI:  if (pulser_busy_i || (r_cnt >= BW_LAST)) w_next = S_WAIT_LO;
            S_WAIT_LO:  if (!pulser_busy_i) w_next = CD_SKIP ? S_ADVANCE : S_COOLDOWN;
            S_COOLDOWN: if (r_cnt >= CD_LAST) w_next = S_ADVANCE;
            S_ADVANCE:  w_next = (w_rep_more || !w_last_point) ? S_ATTEMPT : S_DONE;
            S_DONE:     w_next = S_IDLE;
            default:    w_next = S_IDLE;
         endcase
      end
   end

   always_comb begin
      pulse_en_o = 1'b0;
      reset_en_o = 1'b0;
      done_o     = 1'b0;
      busy_o     = (r_state != S_IDLE);
      case (r_state)
         S_FIRE:    pulse_en_o = 1'b1;
`ifdef SWEEP_RESET_EN
         S_RST_REQ: reset_en_o = 1'b1;
`endif
         S_DONE:    done_o = 1'b1;
         default:   ;
      endcase
   end

   // Dwell counter restarts on every state change; WAIT_HI and COOLDOWN measure against it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt <= 16'd0;
      end else if (r_state != w_next) begin
         r_cnt <= 16'd0;
      end else if (r_cnt != 16'hFFFF) begin
         r_cnt <= r_cnt + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_dly_end   <= delay_end_i;
         r_dly_step  <= delay_step_i;
         r_wid_start <= width_start_i;
         r_wid_end   <= width_end_i;
         r_wid_step  <= width_step_i;
         r_rep       <= repeat_i;
      end
   end

   // Point registers move only at start or in ADVANCE; abort freezes them at their last values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_delay <= 16'd0;
         r_width <= 8'd0;
         r_att   <= 8'd0;
      end else if (w_accept) begin
         r_delay <= delay_start_i;
         r_width <= width_start_i;
         r_att   <= 8'd0;
      end else if ((r_state == S_ADVANCE) && !abort_i) begin
         if (w_rep_more) begin
            r_att <= w_att_nxt[7:0];
         end else begin
            r_att <= 8'd0;
            if (!w_wid_wrap) begin
               r_width <= w_wid_sum[7:0];
            end else if (!w_dly_wrap) begin
               r_width <= r_wid_start;
               r_delay <= w_dly_sum[15:0];
            end
         end
      end
   end

   assign delay_o = r_delay;
   assign width_o = r_width;

endmodule

// File: tb/tb_glitch_sweep.sv
// tb_glitch_sweep: directed scoreboard bench for glitch_sweep; stimulus queues the expected
// (delay, width, spacing) of each attempt strobe and a monitor process checks them as they appear.
`timescale 1ns/1ps
module tb_glitch_sweep;
   localparam int CD         = 10;
   localparam int BWM        = 4;
   localparam int PB         = 5;
   localparam int PER_BUSY   = 1 + 1 + PB + CD + 1;
   localparam int PER_NOBUSY = 1 + BWM + 1 + CD + 1;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start_i = 1'b0;
   logic        abort_i = 1'b0;
   logic [15:0] delay_start_i = '0, delay_end_i = '0, delay_step_i = '0;
   logic [7:0]  width_start_i = '0, width_end_i = '0, width_step_i = '0;
   logic [7:0]  repeat_i = '0;
   logic        pulser_busy_i;
   logic        reset_done_i;
   logic [15:0] delay_o;
   logic [7:0]  width_o;
   logic        pulse_en_o, reset_en_o, busy_o, done_o;

   glitch_sweep #(.COOLDOWN_CYCLES(CD), .BUSY_WAIT_MAX(BWM)) dut (
      .clk(clk), .rst(rst), .start_i(start_i), .abort_i(abort_i),
      .delay_start_i(delay_start_i), .delay_end_i(delay_end_i), .delay_step_i(delay_step_i),
      .width_start_i(width_start_i), .width_end_i(width_end_i), .width_step_i(width_step_i),
      .repeat_i(repeat_i), .pulser_busy_i(pulser_busy_i), .reset_done_i(reset_done_i),
      .delay_o(delay_o), .width_o(width_o), .pulse_en_o(pulse_en_o), .reset_en_o(reset_en_o),
      .busy_o(busy_o), .done_o(done_o)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Pulser and resetter models: busy for PB cycles after a fire; reset done 3 cycles after request.
   bit model_en = 1'b1;
   int busy_cnt = 0;
   int rd_cnt   = 0;
   always @(posedge clk) begin
      if (reset_en_o) rd_cnt <= 3;
      else if (rd_cnt > 0) rd_cnt <= rd_cnt - 1;
      if (model_en && (pulse_en_o || reset_done_i)) busy_cnt <= PB;
      else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
   end
   assign pulser_busy_i = (busy_cnt != 0);
   assign reset_done_i  = (rd_cnt == 1);

   logic mon_strobe, mon_other;
`ifdef SWEEP_RESET_EN
   assign mon_strobe = reset_en_o;
   assign mon_other  = pulse_en_o;
`else
   assign mon_strobe = pulse_en_o;
   assign mon_other  = reset_en_o;
`endif

   function automatic int gapv(input int g);
`ifdef SWEEP_RESET_EN
      return 0;
`else
      return g;
`endif
   endfunction

   typedef struct {
      logic [15:0] d;
      logic [7:0]  w;
      int          gap;
   } exp_t;
   exp_t q[$];

   int n_checks = 0;
   int n_fail   = 0;
   int n_strobe = 0;
   int n_done   = 0;
   int n_other  = 0;
   int last_cyc = 0;
   int exp_done_gap = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push(input logic [15:0] d, input logic [7:0] w, input int gap);
      exp_t e;
      e.d = d; e.w = w; e.gap = gapv(gap);
      q.push_back(e);
   endtask

   always @(negedge clk) begin
      if (rst) begin
         if (mon_strobe) begin
            n_strobe++;
            chk("strobe_expected", (q.size() > 0), 1);
            if (q.size() > 0) begin
               exp_t e;
               e = q.pop_front();
               chk("strobe_delay", delay_o, e.d);
               chk("strobe_width", width_o, e.w);
               if (e.gap != 0) chk("strobe_spacing", cyc - last_cyc, e.gap);
            end
            last_cyc = cyc;
         end
         if (mon_other) n_other++;
         if (done_o) begin
            n_done++;
            if (exp_done_gap != 0) chk("done_spacing", cyc - last_cyc, exp_done_gap);
         end
      end
   end

   task automatic set_ranges(input logic [15:0] ds, de, dst, input logic [7:0] ws, we, wst, rep);
      delay_start_i = ds; delay_end_i = de; delay_step_i = dst;
      width_start_i = ws; width_end_i = we; width_step_i = wst;
      repeat_i = rep;
   endtask

   task automatic wait_done(input int limit);
      bit got = 1'b0;
      for (int i = 0; i < limit && !got; i++) begin
         @(negedge clk);
         if (done_o) got = 1'b1;
      end
      chk("done_seen", got, 1);
   endtask

   task automatic run_sweep(input logic [15:0] ds, de, dst, input logic [7:0] ws, we, wst, rep,
                            input int n_exp, input int period);
      int s0 = n_strobe;
      int d0 = n_done;
      exp_done_gap = gapv(period);
      @(negedge clk);
      set_ranges(ds, de, dst, ws, we, wst, rep);
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      chk("start_busy", busy_o, 1);
      chk("start_delay", delay_o, ds);
      chk("start_width", width_o, ws);
      chk("start_strobe", mon_strobe, 1);
      wait_done(3000);
      @(negedge clk);
      chk("busy_after_done", busy_o, 0);
      chk("strobe_count", n_strobe - s0, n_exp);
      chk("done_count", n_done - d0, 1);
      chk("queue_drained", q.size(), 0);
      exp_done_gap = 0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int s0;
      int d0;
      bit got;

      repeat (3) @(negedge clk);
      chk("rst_delay", delay_o, 0);
      chk("rst_width", width_o, 0);
      chk("rst_pulse", pulse_en_o, 0);
      chk("rst_reset_en", reset_en_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_done", done_o, 0);
      rst = 1'b1;
      repeat (2) @(negedge clk);

      // 3x2 grid with end values hit exactly
      push(100, 2, 0); push(100, 4, PER_BUSY); push(200, 2, PER_BUSY);
      push(200, 4, PER_BUSY); push(300, 2, PER_BUSY); push(300, 4, PER_BUSY);
      run_sweep(100, 300, 100, 2, 4, 2, 1, 6, PER_BUSY);

      // single point, repeat 0 then repeat 3
      push(50, 1, 0);
      run_sweep(50, 50, 1, 1, 1, 1, 0, 1, PER_BUSY);
      push(50, 1, 0); push(50, 1, PER_BUSY); push(50, 1, PER_BUSY);
      run_sweep(50, 50, 1, 1, 1, 1, 3, 3, PER_BUSY);

      // carry out on both axes
      push(16'hFFF0, 250, 0);
      run_sweep(16'hFFF0, 16'hFFFF, 16'h0020, 250, 255, 10, 1, 1, PER_BUSY);

      // delay start > end, width end not on the step grid
      push(30, 1, 0); push(30, 3, PER_BUSY); push(30, 5, PER_BUSY);
      run_sweep(30, 20, 5, 1, 6, 2, 1, 3, PER_BUSY);

      // pulser never raises busy
      model_en = 1'b0;
      push(10, 5, 0); push(10, 7, PER_NOBUSY);
      run_sweep(10, 10, 5, 5, 7, 2, 1, 2, PER_NOBUSY);
      model_en = 1'b1;

      // abort during cooldown of the 2nd attempt, plus ignored start and mid-sweep input changes
      push(100, 2, 0); push(200, 2, PER_BUSY);
      s0 = n_strobe; d0 = n_done;
      @(negedge clk);
      set_ranges(100, 300, 100, 2, 2, 0, 1);
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      repeat (3) @(negedge clk);
      set_ranges(999, 2000, 1, 77, 200, 1, 5);
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      chk("ignored_start_delay", delay_o, 100);
      chk("ignored_start_width", width_o, 2);
      got = 1'b0;
      for (int i = 0; i < 200 && !got; i++) begin
         @(negedge clk);
         if (n_strobe - s0 >= 2) got = 1'b1;
      end
      chk("second_attempt_seen", got, 1);
      repeat (10) @(negedge clk);
      abort_i = 1'b1;
      @(negedge clk);
      abort_i = 1'b0;
      chk("abort_busy", busy_o, 0);
      chk("abort_hold_delay", delay_o, 200);
      chk("abort_hold_width", width_o, 2);
      repeat (40) @(negedge clk);
      chk("abort_strobes", n_strobe - s0, 2);
      chk("abort_no_done", n_done - d0, 0);
      chk("abort_queue", q.size(), 0);

      // start coinciding with abort
      start_i = 1'b1; abort_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0; abort_i = 1'b0;
      chk("start_abort_busy", busy_o, 0);
      chk("start_abort_strobe", mon_strobe, 0);
      repeat (3) @(negedge clk);

      // asynchronous reset while waiting for busy to fall
      push(40, 3, 0);
      set_ranges(40, 40, 1, 3, 3, 1, 1);
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      got = 1'b0;
      for (int i = 0; i < 50 && !got; i++) begin
         @(negedge clk);
         if (pulser_busy_i) got = 1'b1;
      end
      chk("busy_seen_before_reset", got, 1);
      repeat (2) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      chk("arst_busy", busy_o, 0);
      chk("arst_delay", delay_o, 0);
      chk("arst_width", width_o, 0);
      chk("arst_pulse", pulse_en_o, 0);
      chk("arst_reset_en", reset_en_o, 0);
      chk("arst_done", done_o, 0);
      repeat (10) @(negedge clk);
      rst = 1'b1;
      chk("arst_queue", q.size(), 0);

      chk("other_strobe_count", n_other, 0);
      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
